// File: rtl/id_ex_skid.sv
// id_ex_skid: two-entry skid buffer between decode and execute.
// Ports:
//   clk, rst_n (sync, active-low), flush
//   in_valid/in_ready, id_instr/id_a/id_b, id_invA/id_invB/id_Cin  - decode side
//   out_valid/out_ready, ex_instr/ex_a/ex_b, ex_invA/ex_invB/ex_Cin - execute side
//   stall_cnt, flush_cnt - saturating counters, present only with ID_EX_SKID_STAT_EN
module id_ex_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] id_instr,
    input  logic [15:0] id_a,
    input  logic [15:0] id_b,
    input  logic        id_invA,
    input  logic        id_invB,
    input  logic        id_Cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] ex_instr,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic        ex_invA,
    output logic        ex_invB,
    output logic        ex_Cin
`ifdef ID_EX_SKID_STAT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`else
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    localparam logic [50:0] NOP = {16'h0800, 35'd0};
    state_t      state_q;
    logic [50:0] main_q, skid_q, in_pay;
    logic        acc, cons;
    assign in_pay    = {id_instr, id_a, id_b, id_invA, id_invB, id_Cin};
    assign in_ready  = state_q != FULL;
    assign out_valid = state_q != EMPTY;
    assign acc       = in_valid && in_ready;
    assign cons      = out_valid && out_ready;
    // main_q is reloaded with NOP whenever it empties, so outputs come straight from it
    assign {ex_instr, ex_a, ex_b, ex_invA, ex_invB, ex_Cin} = main_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= NOP;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= NOP;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    main_q  <= in_pay;
                    state_q <= ONE;
                end
                ONE: begin
                    if (acc && cons) main_q <= in_pay;
                    else if (acc) begin
                        skid_q  <= in_pay;
                        state_q <= FULL;
                    end else if (cons) begin
                        main_q  <= NOP;
                        state_q <= EMPTY;
                    end
                end
                FULL: if (cons) begin
                    main_q  <= skid_q;
                    state_q <= ONE;
                end
                default: begin
                    main_q  <= NOP;
                    state_q <= EMPTY;
                end
            endcase
        end
    end
`ifdef ID_EX_SKID_STAT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (in_valid && !in_ready && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush && out_valid && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end
`else
`endif
endmodule

// File: doc/id_ex_skid.md
ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-003 SHALL have port: flush  input  1  discard all held entries (branch mispredict/exception).
REQ-004 SHALL have port: in_valid  input  1  decode stage presents an entry.
REQ-005 SHALL have port: in_ready  output  1  block can accept an entry this cycle.
REQ-006 SHALL have ports: id_instr  input  16, id_a  input  16, id_b  input  16  instruction word, operand A, operand B from decode.
REQ-007 SHALL have ports: id_invA, id_invB, id_Cin  input  1 each  ALU inversion/carry controls from the decode-stage inversion decoder.
REQ-008 SHALL have port: out_valid  output  1  execute-stage entry valid.
REQ-009 SHALL have port: out_ready  input  1  execute stage consumes the entry this cycle.
REQ-010 SHALL have ports: ex_instr, ex_a, ex_b  output  16 each; ex_invA, ex_invB, ex_Cin  output  1 each  registered copies toward the ALU.

Function
REQ-011 SHALL implement a two-entry skid buffer (main register drives outputs; skid register holds one overflow entry).
REQ-012 SHALL accept an entry when in_valid && in_ready; SHALL consume main when out_valid && out_ready.
REQ-013 SHALL drive in_ready = !skid_valid, from a register only (no combinational path from out_ready).
REQ-014 SHALL have states EMPTY (none), ONE (main only), FULL (main+skid); out_valid = (state != EMPTY).
REQ-015 EMPTY: accept -> ONE, entry in main, visible at outputs next cycle (latency 1).
REQ-016 ONE: accept & consume -> ONE, new entry replaces main; accept & !consume -> FULL, entry into skid; consume & !accept -> EMPTY; neither -> ONE, hold.
REQ-017 FULL: consume -> ONE, skid moves to main same edge; !consume -> FULL, hold; no accept possible.
REQ-018 Entries SHALL leave in acceptance order; no entry dropped or duplicated except by flush/reset.
REQ-019 When out_valid=0, ex_instr SHALL be 16'h0800 (NOP) and ex_a, ex_b, ex_invA, ex_invB, ex_Cin SHALL be 0.
REQ-020 Payload fields (16+16+16+3 bits) SHALL pass unmodified; no arithmetic performed.
REQ-021 flush=1: next state EMPTY, both entries discarded, outputs as REQ-019; flush wins over simultaneous accept (input entry dropped) and consume.
REQ-022 Outputs held stable while out_valid && !out_ready.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force state EMPTY, in_ready=1, out_valid=0, outputs per REQ-019, counters 0.
REQ-024 Reset SHALL override flush and all handshakes, including mid-operation in FULL.
REQ-025 Asserting rst_n without a clock edge SHALL change nothing.

Configuration
REQ-026 Macro ID_EX_SKID_STAT_EN SHALL gate performance counters.
REQ-027 Defined: outputs stall_cnt[15:0] (+1 per cycle in_valid && !in_ready) and flush_cnt[15:0] (+1 per flush cycle with out_valid=1), both saturating at 16'hFFFF, cleared by reset only.
REQ-028 Undefined: no counter ports or logic; all other behaviour identical.

Verification
REQ-029 Reset then in_valid=1, id_instr=16'h4123, id_invA=1, id_Cin=1, out_ready=1 -> next cycle out_valid=1, ex_instr=16'h4123, ex_invA=1, ex_Cin=1.
REQ-030 out_ready=0, three back-to-back entries A,B,C -> A in main, B in skid, in_ready=0, C held upstream; out_ready=1 -> outputs A, B, C in order, one per cycle.
REQ-031 FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, ex_instr=16'h0800, in_ready=1, incoming entry not delivered.
REQ-032 FULL, rst_n=0 one edge -> EMPTY, out_valid=0, all outputs per REQ-019.
REQ-033 Continuous in_valid=1, out_ready=1 for 100 cycles -> 100 entries delivered, in_ready never 0.
REQ-034 With ID_EX_SKID_STAT_EN: hold FULL, in_valid=1 for 70000 cycles -> stall_cnt=16'hFFFF.
